// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl
// Transaction sequencer between the byte-level SPI slave and a small register
// bus. Each chip-select-low period is one frame: a command byte {R/W, addr}
// followed by data bytes. Writes strobe o_reg_wr per data byte; reads strobe
// o_reg_rd and preload o_tx_data for the next MISO byte slot. The address
// optionally auto-increments (wrapping modulo 2^ADDR_W).
//
// Ports:
//   i_clk, i_rst_n      system clock, asynchronous active-low reset
//   i_cs_n              raw SPI chip select (asynchronous, synchronized here)
//   i_rx_done/i_rx_data byte-received pulse and byte from the SPI slave
//   o_tx_data           byte the slave shifts out on the next byte slot
//   o_reg_addr          register bus address
//   o_reg_wr/o_reg_wdata  one-cycle write strobe and its data
//   o_reg_rd/i_reg_rdata  one-cycle read strobe; data returns one cycle later
//   o_busy              high while a frame is active
//   o_txn_done          one-cycle pulse at the end of a frame that had a command
module spi_reg_ctrl #(
    parameter int unsigned ADDR_W   = 7,
    parameter bit          AUTO_INC = 1'b1,
    parameter logic [7:0]  IDLE_TX  = 8'h8F
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cs_n,
    input  logic              i_rx_done,
    input  logic [7:0]        i_rx_data,
    output logic [7:0]        o_tx_data,
    output logic [ADDR_W-1:0] o_reg_addr,
    output logic              o_reg_wr,
    output logic [7:0]        o_reg_wdata,
    output logic              o_reg_rd,
    input  logic [7:0]        i_reg_rdata,
    output logic              o_busy,
    output logic              o_txn_done
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WR_DATA,
        RD_ISSUE,
        RD_CAPT,
        RD_DATA
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_STEP = AUTO_INC ? ADDR_W'(1) : '0;

    state_t            state;
    logic [ADDR_W-1:0] addr;

    logic       cs_meta;
    logic       cs_s;
    logic       cs_d;
    logic [1:0] sync_vld;
    logic       armed;
    logic       cs_fall;
    logic       cs_rise;

    assign cs_fall = cs_d & ~cs_s;
    assign cs_rise = ~cs_d & cs_s;

    // Chip-select synchronizer and edge detector. The sync flops reset high,
    // so if CS is already low when reset releases, the shift-in would look
    // like a falling edge. 'armed' only sets once a genuinely sampled high
    // CS has been seen, so a frame already running at reset release is
    // ignored until CS goes high and low again.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cs_meta  <= 1'b1;
            cs_s     <= 1'b1;
            cs_d     <= 1'b1;
            sync_vld <= '0;
            armed    <= 1'b0;
        end else begin
            cs_meta  <= i_cs_n;
            cs_s     <= cs_meta;
            cs_d     <= cs_s;
            sync_vld <= {sync_vld[0], 1'b1};
            if (sync_vld[1] && cs_s) begin
                armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            addr        <= '0;
            o_tx_data   <= IDLE_TX;
            o_reg_addr  <= '0;
            o_reg_wr    <= 1'b0;
            o_reg_wdata <= '0;
            o_reg_rd    <= 1'b0;
            o_busy      <= 1'b0;
            o_txn_done  <= 1'b0;
        end else begin
            o_reg_wr   <= 1'b0;
            o_reg_rd   <= 1'b0;
            o_txn_done <= 1'b0;

            // Frame end takes priority over any byte arriving in the same
            // cycle; a pending read capture is dropped with it.
            if (state != IDLE && cs_rise) begin
                state      <= IDLE;
                o_tx_data  <= IDLE_TX;
                o_busy     <= 1'b0;
                o_txn_done <= (state != CMD);
            end else begin
                case (state)
                    IDLE: begin
                        o_tx_data <= IDLE_TX;
                        if (cs_fall && armed) begin
                            state  <= CMD;
                            o_busy <= 1'b1;
                        end
                    end
                    CMD: begin
                        if (i_rx_done) begin
                            addr <= i_rx_data[ADDR_W-1:0];
                            if (i_rx_data[7]) begin
                                // Strobe issued on entry so RD_ISSUE is the
                                // strobe cycle.
                                state      <= RD_ISSUE;
                                o_reg_rd   <= 1'b1;
                                o_reg_addr <= i_rx_data[ADDR_W-1:0];
                            end else begin
                                state     <= WR_DATA;
                                o_tx_data <= i_rx_data;
                            end
                        end
                    end
                    WR_DATA: begin
                        if (i_rx_done) begin
                            o_reg_wr    <= 1'b1;
                            o_reg_wdata <= i_rx_data;
                            o_reg_addr  <= addr;
                            addr        <= addr + ADDR_STEP;
                            o_tx_data   <= i_rx_data;
                        end
                    end
                    RD_ISSUE: begin
                        state <= RD_CAPT;
                    end
                    RD_CAPT: begin
                        o_tx_data <= i_reg_rdata;
                        addr      <= addr + ADDR_STEP;
                        state     <= RD_DATA;
                    end
                    RD_DATA: begin
                        if (i_rx_done) begin
                            state      <= RD_ISSUE;
                            o_reg_rd   <= 1'b1;
                            o_reg_addr <= addr;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed testbench for spi_reg_ctrl: write/read bursts, address wrap with
// and without auto-increment, aborted frames, byte coincident with CS rise,
// and asynchronous reset in the middle of a read.
module tb_spi_reg_ctrl;

    logic       clk;
    logic       rst_n;
    logic       cs_n;
    logic       rx_done;
    logic [7:0] rx_data;
    logic [7:0] reg_rdata;

    logic [7:0] tx_a,    tx_b;
    logic [6:0] addr_a,  addr_b;
    logic       wr_a,    wr_b;
    logic [7:0] wdata_a, wdata_b;
    logic       rd_a,    rd_b;
    logic       busy_a,  busy_b;
    logic       done_a,  done_b;

    spi_reg_ctrl u_dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_cs_n      (cs_n),
        .i_rx_done   (rx_done),
        .i_rx_data   (rx_data),
        .o_tx_data   (tx_a),
        .o_reg_addr  (addr_a),
        .o_reg_wr    (wr_a),
        .o_reg_wdata (wdata_a),
        .o_reg_rd    (rd_a),
        .i_reg_rdata (reg_rdata),
        .o_busy      (busy_a),
        .o_txn_done  (done_a)
    );

    spi_reg_ctrl #(.AUTO_INC(1'b0)) u_dut_noinc (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_cs_n      (cs_n),
        .i_rx_done   (rx_done),
        .i_rx_data   (rx_data),
        .o_tx_data   (tx_b),
        .o_reg_addr  (addr_b),
        .o_reg_wr    (wr_b),
        .o_reg_wdata (wdata_b),
        .o_reg_rd    (rd_b),
        .i_reg_rdata (reg_rdata),
        .o_busy      (busy_b),
        .o_txn_done  (done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Register model driving read data one cycle after the strobe.
    logic [7:0] mem [128];
    always @(posedge clk) begin
        if (rd_a) reg_rdata <= mem[addr_a];
    end

    int          cyc = 0;
    int          last_rx = 0;
    logic [15:0] wr_q_a [$];
    logic [15:0] wr_q_b [$];
    logic [6:0]  rd_q   [$];
    int          lat_q  [$];
    int          txn_cnt = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rx_done) last_rx = cyc;
        if (wr_a)   wr_q_a.push_back({1'b0, addr_a, wdata_a});
        if (wr_b)   wr_q_b.push_back({1'b0, addr_b, wdata_b});
        if (rd_a) begin
            rd_q.push_back(addr_a);
            lat_q.push_back(cyc - last_rx);
        end
        if (done_a) txn_cnt++;
    end

    task automatic clear_logs();
        wr_q_a.delete();
        wr_q_b.delete();
        rd_q.delete();
        lat_q.delete();
        txn_cnt = 0;
    endtask

    task automatic cs_low();
        @(posedge clk); #1;
        cs_n = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic cs_high();
        @(posedge clk); #1;
        cs_n = 1'b1;
        repeat (6) @(posedge clk);
    endtask

    // One SPI byte slot: MISO is whatever o_tx_data holds when the byte ends.
    task automatic spi_byte(input logic [7:0] b, output logic [7:0] miso);
        @(posedge clk); #1;
        miso    = tx_a;
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk); #1;
        rx_done = 1'b0;
        repeat (8) @(posedge clk);
    endtask

    logic [7:0] m0, m1, m2;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        cs_n      = 1'b1;
        rx_done   = 1'b0;
        rx_data   = '0;
        reg_rdata = '0;
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'hA1;
        mem[8'h11] = 8'hB2;
        mem[8'h12] = 8'hC3;

        repeat (3) @(posedge clk); #1;
        chk("rst_tx",    tx_a,    8'h8F);
        chk("rst_addr",  addr_a,  7'h00);
        chk("rst_wr",    wr_a,    1'b0);
        chk("rst_rd",    rd_a,    1'b0);
        chk("rst_wdata", wdata_a, 8'h00);
        chk("rst_busy",  busy_a,  1'b0);
        chk("rst_done",  done_a,  1'b0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        // Write burst
        clear_logs();
        cs_low();
        chk("wr_busy", busy_a, 1'b1);
        spi_byte(8'h05, m0);
        spi_byte(8'h11, m1);
        spi_byte(8'h22, m2);
        cs_high();
        chk("wr_cnt",   wr_q_a.size(), 2);
        chk("wr0",      wr_q_a[0], 16'h0511);
        chk("wr1",      wr_q_a[1], 16'h0622);
        chk("wr_noinc_cnt", wr_q_b.size(), 2);
        chk("wr_noinc0", wr_q_b[0], 16'h0511);
        chk("wr_noinc1", wr_q_b[1], 16'h0522);
        chk("wr_no_rd", rd_q.size(), 0);
        chk("wr_txn",   txn_cnt, 1);
        chk("wr_tx_idle", tx_a, 8'h8F);
        chk("wr_busy_end", busy_a, 1'b0);

        // Read burst
        clear_logs();
        cs_low();
        spi_byte(8'h90, m0);
        spi_byte(8'h00, m1);
        spi_byte(8'h00, m2);
        cs_high();
        chk("rd_miso0", m0, 8'h8F);
        chk("rd_miso1", m1, 8'hA1);
        chk("rd_miso2", m2, 8'hB2);
        chk("rd_cnt",   rd_q.size(), 3);
        chk("rd_addr0", rd_q[0], 7'h10);
        chk("rd_addr1", rd_q[1], 7'h11);
        chk("rd_addr2", rd_q[2], 7'h12);
        chk("rd_lat0",  lat_q[0], 1);
        chk("rd_lat1",  lat_q[1], 1);
        chk("rd_lat2",  lat_q[2], 1);
        chk("rd_no_wr", wr_q_a.size(), 0);
        chk("rd_txn",   txn_cnt, 1);
        chk("rd_tx_idle", tx_a, 8'h8F);

        // Address wrap
        clear_logs();
        cs_low();
        spi_byte(8'h7F, m0);
        spi_byte(8'hAA, m1);
        spi_byte(8'hBB, m2);
        cs_high();
        chk("wrap_cnt", wr_q_a.size(), 2);
        chk("wrap0",    wr_q_a[0], 16'h7FAA);
        chk("wrap1",    wr_q_a[1], 16'h00BB);
        chk("wrap_noinc0", wr_q_b[0], 16'h7FAA);
        chk("wrap_noinc1", wr_q_b[1], 16'h7FBB);

        // Empty frame: CS toggles with no bytes
        clear_logs();
        cs_low();
        cs_high();
        chk("empty_txn",  txn_cnt, 0);
        chk("empty_busy", busy_a, 1'b0);
        chk("empty_wr",   wr_q_a.size(), 0);

        // Command byte only, then CS high
        clear_logs();
        cs_low();
        spi_byte(8'h83, m0);
        cs_high();
        chk("abort_wr",   wr_q_a.size(), 0);
        chk("abort_txn",  txn_cnt, 1);
        chk("abort_busy", busy_a, 1'b0);
        chk("abort_tx",   tx_a, 8'h8F);

        // Byte coincident with CS rise during WR_DATA
        clear_logs();
        cs_low();
        spi_byte(8'h05, m0);
        spi_byte(8'h11, m1);
        @(posedge clk); #1;
        cs_n = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        rx_data = 8'h22;
        rx_done = 1'b1;
        @(posedge clk); #1;
        rx_done = 1'b0;
        repeat (6) @(posedge clk); #1;
        chk("simul_wr_cnt", wr_q_a.size(), 1);
        chk("simul_wr0",    wr_q_a[0], 16'h0511);
        chk("simul_busy",   busy_a, 1'b0);
        chk("simul_txn",    txn_cnt, 1);

        // Reset while RD_CAPT is active
        clear_logs();
        cs_low();
        spi_byte(8'h90, m0);
        chk("rrst_pre_tx", tx_a, 8'hA1);
        @(posedge clk); #1;
        rx_data = 8'h00;
        rx_done = 1'b1;
        @(posedge clk); #1;
        rx_done = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rrst_tx",   tx_a,   8'h8F);
        chk("rrst_rd",   rd_a,   1'b0);
        chk("rrst_busy", busy_a, 1'b0);
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        clear_logs();
        // CS still low from before reset: this frame must be ignored
        spi_byte(8'h05, m0);
        spi_byte(8'h33, m1);
        chk("rrst_ign_wr",   wr_q_a.size(), 0);
        chk("rrst_ign_rd",   rd_q.size(), 0);
        chk("rrst_ign_busy", busy_a, 1'b0);
        cs_high();
        chk("rrst_ign_txn", txn_cnt, 0);
        clear_logs();
        cs_low();
        spi_byte(8'h20, m0);
        spi_byte(8'h5A, m1);
        cs_high();
        chk("rrst_next_cnt", wr_q_a.size(), 1);
        chk("rrst_next_wr",  wr_q_a[0], 16'h205A);
        chk("rrst_next_txn", txn_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
